// File: rtl/pcap_arm_ctrl.sv
// Position-capture arm/run controller.
// Arms on a register strobe, runs while the bit-bus enable is high, and
// forwards accepted capture edges to the datapath. A run ends on disarm,
// on a capture that is too close to the previous one, on DMA overflow,
// or when enable falls. All outputs are registered.
module pcap_arm_ctrl #(
  parameter int unsigned MIN_GAP = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ARM,
  input  logic             DISARM,
  input  logic [1:0]       CAPTURE_EDGE,
  input  logic             enable_i,
  input  logic             capture_i,
  input  logic             dma_full_i,
  output logic             pcap_enable_o,
  output logic             pcap_capture_o,
  output logic             pcap_actv_o,
  output logic             pcap_done_o,
  output logic [1:0]       pcap_status_o,
  output logic [CNT_W-1:0] capt_cnt_o
);

  localparam int unsigned GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_DISARMED = 2'd1;
  localparam logic [1:0] ST_DMA_OVF  = 2'd2;
  localparam logic [1:0] ST_TOO_SOON = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               enable_q, capture_q;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [1:0]         status_d;
  logic               done_d, strobe_d;

  logic en_rise, en_fall, cap_rise, cap_fall, cap_sel, too_close;

  assign en_rise  =  enable_i  & ~enable_q;
  assign en_fall  = ~enable_i  &  enable_q;
  assign cap_rise =  capture_i & ~capture_q;
  assign cap_fall = ~capture_i &  capture_q;

  // Select which capture edge(s) count; encoding 3 behaves as rising.
  always_comb begin
    cap_sel = cap_rise;
    case (CAPTURE_EDGE)
      2'd1:    cap_sel = cap_fall;
      2'd2:    cap_sel = cap_rise | cap_fall;
      default: cap_sel = cap_rise;
    endcase
  end

  assign too_close = cap_sel && (gap_q < GAP_MAX);

  // Next-state, counters and output strobes; priority within RUNNING is
  // disarm > too close > DMA overflow > enable fall > capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = capt_cnt_o;
    status_d = pcap_status_o;
    gap_d    = gap_q;
    done_d   = 1'b0;
    strobe_d = 1'b0;

    if (gap_q < GAP_MAX) begin
      gap_d = gap_q + GAP_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (ARM && !DISARM) begin
          state_d  = ARMED;
          status_d = ST_OK;
          cnt_d    = '0;
        end
      end
      ARMED: begin
        if (DISARM) begin
          state_d  = IDLE;
          status_d = ST_DISARMED;
          done_d   = 1'b1;
        end else if (en_rise) begin
          state_d = RUNNING;
          gap_d   = GAP_MAX;
        end
      end
      RUNNING: begin
        if (DISARM) begin
          state_d  = IDLE;
          status_d = ST_DISARMED;
          done_d   = 1'b1;
        end else if (too_close) begin
          state_d  = IDLE;
          status_d = ST_TOO_SOON;
          done_d   = 1'b1;
        end else if (cap_sel && dma_full_i) begin
          state_d  = IDLE;
          status_d = ST_DMA_OVF;
          done_d   = 1'b1;
        end else if (en_fall) begin
          state_d  = IDLE;
          status_d = ST_OK;
          done_d   = 1'b1;
        end else if (cap_sel) begin
          strobe_d = 1'b1;
          gap_d    = GAP_W'(1);
          if (capt_cnt_o != '1) begin
            cnt_d = capt_cnt_o + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, edge-detect history and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      enable_q       <= 1'b0;
      capture_q      <= 1'b0;
      gap_q          <= '0;
      capt_cnt_o     <= '0;
      pcap_status_o  <= '0;
      pcap_done_o    <= 1'b0;
      pcap_capture_o <= 1'b0;
      pcap_enable_o  <= 1'b0;
      pcap_actv_o    <= 1'b0;
    end else begin
      state_q        <= state_d;
      enable_q       <= enable_i;
      capture_q      <= capture_i;
      gap_q          <= gap_d;
      capt_cnt_o     <= cnt_d;
      pcap_status_o  <= status_d;
      pcap_done_o    <= done_d;
      pcap_capture_o <= strobe_d;
      pcap_enable_o  <= (state_d == RUNNING);
      pcap_actv_o    <= (state_d != IDLE);
    end
  end

endmodule
